// File: rtl/usb_txn_sequencer.sv
// ---------------------------------------------------------------------------
// usb_txn_sequencer
//
// Host-side transaction sequencer for the USB serial link. Issues the token,
// data and handshake send requests to the transmit datapath, arms the data
// and ACK/NAK receivers in the right order, owns the DP/DM direction (bus
// turnaround), retries NAKed or failed attempts and reports one final status.
//
// Parameters:
//   MAX_RETRY  retries allowed after the first attempt before giving up (>=1)
//   TURN_CYC   idle cycles inserted whenever the bus changes direction (>=1)
//   WDOG_CYC   whole-transaction watchdog limit (only with USB_TXN_WDOG_EN)
//
// Configuration macro:
//   USB_TXN_WDOG_EN  when defined, a watchdog counts every busy cycle and
//                    forces FAIL once it reaches WDOG_CYC. When undefined
//                    the sequencer waits indefinitely on its inputs.
//
// Ports:
//   clk, rst                       clock, asynchronous active-high reset
//   txn_start, txn_is_in           start pulse and direction (1=IN, 0=OUT)
//   abort                          cancel the running transaction
//   tx_done                        transmit datapath finished a packet
//   rx_ack, rx_nak, rx_hs_fail     handshake receiver results
//   rx_data_ok, rx_data_fail       data receiver results
//   send_token, send_data, send_hs request pulses to the transmit datapath
//   hs_is_nak                      handshake type while in SEND_HS
//   recv_data, recv_hand           receiver arm pulses
//   drive_bus                      1 = host drives DP/DM
//   busy                           transaction in progress
//   txn_done, txn_ok               final status pulse and result
//   retry_cnt                      retries used by current/last transaction
// ---------------------------------------------------------------------------
module usb_txn_sequencer #(
    parameter int MAX_RETRY = 8,
    parameter int TURN_CYC  = 2
`ifdef USB_TXN_WDOG_EN
    ,
    parameter int WDOG_CYC  = 4095
`endif
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           txn_start,
    input  logic                           txn_is_in,
    input  logic                           abort,
    input  logic                           tx_done,
    input  logic                           rx_ack,
    input  logic                           rx_nak,
    input  logic                           rx_hs_fail,
    input  logic                           rx_data_ok,
    input  logic                           rx_data_fail,
    output logic                           send_token,
    output logic                           send_data,
    output logic                           send_hs,
    output logic                           hs_is_nak,
    output logic                           recv_data,
    output logic                           recv_hand,
    output logic                           drive_bus,
    output logic                           busy,
    output logic                           txn_done,
    output logic                           txn_ok,
    output logic [$clog2(MAX_RETRY+1)-1:0] retry_cnt
);

    localparam int RW = $clog2(MAX_RETRY + 1);
    localparam int TW = (TURN_CYC > 1) ? $clog2(TURN_CYC) : 1;

    typedef enum logic [3:0] {
        IDLE,
        TOKEN,
        OUT_DATA,
        TURN,
        WAIT_HS,
        IN_DATA,
        SEND_HS,
        RETRY,
        DONE,
        FAIL
    } state_t;

    state_t        state;
    state_t        nxt;
    state_t        turn_tgt;
    state_t        turn_tgt_nxt;
    logic          nak_nxt;
    logic          is_in;
    logic [TW-1:0] turn_cnt;
    logic          enter;
    logic          active;

    // States in which the transaction is still in flight. DONE and FAIL are
    // already reporting the outcome, so abort (and the watchdog) leave them
    // alone rather than producing a second txn_done.
    assign active = (state != IDLE) && (state != DONE) && (state != FAIL);
    assign enter  = (nxt != state);

`ifdef USB_TXN_WDOG_EN
    localparam int WW = $clog2(WDOG_CYC + 1);
    logic [WW-1:0] wdog_cnt;

    // Watchdog counter: restarts with each accepted transaction and counts
    // every busy cycle, saturating at the limit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wdog_cnt <= '0;
        end else if (state == IDLE) begin
            if (txn_start) begin
                wdog_cnt <= '0;
            end
        end else if (wdog_cnt != WW'(WDOG_CYC)) begin
            wdog_cnt <= wdog_cnt + WW'(1);
        end
    end
`endif

    // Next-state decision. Turnarounds go through TURN with the eventual
    // destination parked in turn_tgt; the handshake type chosen in IN_DATA
    // travels with it. Abort overrides everything, the watchdog everything
    // else.
    always_comb begin
        nxt          = state;
        turn_tgt_nxt = turn_tgt;
        nak_nxt      = hs_is_nak;
        case (state)
            IDLE: begin
                if (txn_start) nxt = TOKEN;
            end
            TOKEN: begin
                if (tx_done) begin
                    if (is_in) begin
                        nxt          = TURN;
                        turn_tgt_nxt = IN_DATA;
                    end else begin
                        nxt = OUT_DATA;
                    end
                end
            end
            OUT_DATA: begin
                if (tx_done) begin
                    nxt          = TURN;
                    turn_tgt_nxt = WAIT_HS;
                end
            end
            TURN: begin
                if (turn_cnt == TW'(TURN_CYC - 1)) nxt = turn_tgt;
            end
            WAIT_HS: begin
                // A NAK seen together with an ACK counts as a NAK.
                if (rx_nak || rx_hs_fail) begin
                    nxt = RETRY;
                end else if (rx_ack) begin
                    nxt = DONE;
                end
            end
            IN_DATA: begin
                // Good and bad data in the same cycle counts as bad.
                if (rx_data_fail) begin
                    nxt          = TURN;
                    turn_tgt_nxt = SEND_HS;
                    nak_nxt      = 1'b1;
                end else if (rx_data_ok) begin
                    nxt          = TURN;
                    turn_tgt_nxt = SEND_HS;
                    nak_nxt      = 1'b0;
                end
            end
            SEND_HS: begin
                if (tx_done) nxt = hs_is_nak ? RETRY : DONE;
            end
            RETRY: begin
                nxt = (retry_cnt == RW'(MAX_RETRY)) ? FAIL : TOKEN;
            end
            DONE:    nxt = IDLE;
            FAIL:    nxt = IDLE;
            default: nxt = IDLE;
        endcase
`ifdef USB_TXN_WDOG_EN
        if (active && (wdog_cnt == WW'(WDOG_CYC))) nxt = FAIL;
`endif
        if (active && abort) nxt = FAIL;
    end

    // State register and registered outputs. Request pulses fire only on
    // entry into their state; bus direction, busy and the status outputs are
    // decoded from the state being entered so they line up with it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            turn_tgt   <= IDLE;
            turn_cnt   <= '0;
            is_in      <= 1'b0;
            retry_cnt  <= '0;
            send_token <= 1'b0;
            send_data  <= 1'b0;
            send_hs    <= 1'b0;
            hs_is_nak  <= 1'b0;
            recv_data  <= 1'b0;
            recv_hand  <= 1'b0;
            drive_bus  <= 1'b0;
            busy       <= 1'b0;
            txn_done   <= 1'b0;
            txn_ok     <= 1'b0;
        end else begin
            state      <= nxt;
            turn_tgt   <= turn_tgt_nxt;
            hs_is_nak  <= nak_nxt;
            turn_cnt   <= (state == TURN && nxt == TURN) ? turn_cnt + TW'(1) : '0;
            send_token <= enter && (nxt == TOKEN);
            send_data  <= enter && (nxt == OUT_DATA);
            send_hs    <= enter && (nxt == SEND_HS);
            recv_data  <= enter && (nxt == IN_DATA);
            recv_hand  <= enter && (nxt == WAIT_HS);
            drive_bus  <= (nxt == TOKEN) || (nxt == OUT_DATA) || (nxt == SEND_HS);
            busy       <= (nxt != IDLE);
            txn_done   <= (nxt == DONE) || (nxt == FAIL);
            txn_ok     <= (nxt == DONE);
            if (state == IDLE && txn_start) begin
                is_in     <= txn_is_in;
                retry_cnt <= '0;
            end else if (state == RETRY && nxt == TOKEN) begin
                retry_cnt <= retry_cnt + RW'(1);
            end
        end
    end

endmodule

// File: tb/tb_usb_txn_sequencer.sv
// ---------------------------------------------------------------------------
// tb_usb_txn_sequencer
//
// Self-checking bench for usb_txn_sequencer (MAX_RETRY=2, TURN_CYC=2). The
// bench plays the transmit datapath and the device: it answers each request
// pulse after a chosen delay, with an outcome taken from a per-attempt list.
// The expected number of attempts, final status and retry count come from a
// transaction-level model of the retry rules.
// ---------------------------------------------------------------------------
module tb_usb_txn_sequencer;

    localparam int MAX_RETRY = 2;
    localparam int TURN_CYC  = 2;
    localparam int RW        = $clog2(MAX_RETRY + 1);

    // Which request line a wait refers to.
    localparam int REQ_TOKEN = 0;
    localparam int REQ_DATA  = 1;
    localparam int REQ_HS    = 2;
    localparam int REQ_RDATA = 3;
    localparam int REQ_RHAND = 4;
    localparam int REQ_DONE  = 5;

    // Noise masks {tx_done, rx_ack, rx_nak, rx_hs_fail, rx_data_ok, rx_data_fail}
    localparam logic [5:0] NOISE_TX    = 6'b011111;
    localparam logic [5:0] NOISE_WAITH = 6'b100011;
    localparam logic [5:0] NOISE_IND   = 6'b111100;

    logic          clk = 1'b0;
    logic          rst;
    logic          txn_start, txn_is_in, abort, tx_done;
    logic          rx_ack, rx_nak, rx_hs_fail, rx_data_ok, rx_data_fail;
    logic          send_token, send_data, send_hs, hs_is_nak;
    logic          recv_data, recv_hand, drive_bus, busy, txn_done, txn_ok;
    logic [RW-1:0] retry_cnt;

    int checks = 0;
    int fails  = 0;
    bit noise_en = 1'b0;
    // Per-attempt outcome: 0 = success; OUT: 1 NAK, 2 hs timeout, 3 ACK+NAK;
    // IN: 1 bad data, 2 good+bad together.
    int outc [0:MAX_RETRY];

    usb_txn_sequencer #(.MAX_RETRY(MAX_RETRY), .TURN_CYC(TURN_CYC)) dut (
        .clk(clk), .rst(rst), .txn_start(txn_start), .txn_is_in(txn_is_in),
        .abort(abort), .tx_done(tx_done), .rx_ack(rx_ack), .rx_nak(rx_nak),
        .rx_hs_fail(rx_hs_fail), .rx_data_ok(rx_data_ok), .rx_data_fail(rx_data_fail),
        .send_token(send_token), .send_data(send_data), .send_hs(send_hs),
        .hs_is_nak(hs_is_nak), .recv_data(recv_data), .recv_hand(recv_hand),
        .drive_bus(drive_bus), .busy(busy), .txn_done(txn_done), .txn_ok(txn_ok),
        .retry_cnt(retry_cnt)
    );

    always #5 clk = ~clk;

    // Safety net so a stuck run still ends.
    initial begin
        #1000000;
        $display("[TB] FAIL global_timeout: simulation still running, required finish");
        $fatal(1, "[TB] global timeout");
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clearPulses();
        txn_start = 1'b0; abort = 1'b0; tx_done = 1'b0;
        rx_ack = 1'b0; rx_nak = 1'b0; rx_hs_fail = 1'b0;
        rx_data_ok = 1'b0; rx_data_fail = 1'b0;
    endtask

    function automatic logic reqSig(input int which);
        case (which)
            REQ_TOKEN: return send_token;
            REQ_DATA:  return send_data;
            REQ_HS:    return send_hs;
            REQ_RDATA: return recv_data;
            REQ_RHAND: return recv_hand;
            default:   return txn_done;
        endcase
    endfunction

    // Clock the pulses currently driven in, then watch for a request line.
    // lat counts edges until it appears (-1 on timeout); lows counts the
    // samples before it with the bus released.
    task automatic waitReq(input int which, input int budget, output int lat, output int lows);
        lat  = -1;
        lows = 0;
        for (int i = 1; i <= budget; i++) begin
            tick();
            clearPulses();
            if (reqSig(which)) begin
                lat = i;
                break;
            end
            if (!drive_bus) lows++;
        end
    endtask

    // Hold off the response for d cycles, optionally spraying inputs the
    // current state must ignore and start requests that must be ignored.
    task automatic delayTicks(input int which, input int d, input logic [5:0] mask);
        for (int i = 0; i < d; i++) begin
            if (noise_en && $urandom_range(0, 2) == 0)
                {tx_done, rx_ack, rx_nak, rx_hs_fail, rx_data_ok, rx_data_fail} = 6'($urandom) & mask;
            if (noise_en && $urandom_range(0, 3) == 0) begin
                txn_start = 1'b1;
                txn_is_in = 1'($urandom);
            end
            tick();
            clearPulses();
            checkOutput("req_single_pulse", 32'(reqSig(which)), 0);
            checkOutput("busy_while_waiting", 32'(busy), 1);
        end
    endtask

    task automatic doReset();
        clearPulses();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #3;
        rst = 1'b0;
        tick();
    endtask

    // Run one transaction against outc[] and check it end to end.
    task automatic applyStimulus(input logic is_in, input bit rnd_delay);
        int exp_att, lat, lows, tokens, d;
        bit exp_ok;
        // Model: first successful attempt ends it; otherwise MAX_RETRY+1 tries.
        exp_att = MAX_RETRY + 1;
        exp_ok  = 1'b0;
        for (int a = 0; a <= MAX_RETRY; a++) begin
            if (outc[a] == 0) begin
                exp_att = a + 1;
                exp_ok  = 1'b1;
                break;
            end
        end
        tokens    = 0;
        txn_start = 1'b1;
        txn_is_in = is_in;
        waitReq(REQ_TOKEN, 4, lat, lows);
        checkOutput("start_to_token", lat, 1);
        for (int a = 0; a <= MAX_RETRY; a++) begin
            if (lat >= 0) tokens++;
            checkOutput("token_drive", 32'(drive_bus), 1);
            d = rnd_delay ? $urandom_range(0, 3) : 0;
            delayTicks(REQ_TOKEN, d, NOISE_TX);
            tx_done = 1'b1;
            if (!is_in) begin
                waitReq(REQ_DATA, 6, lat, lows);
                checkOutput("data_lat", lat, 1);
                checkOutput("data_drive", 32'(drive_bus), 1);
                d = rnd_delay ? $urandom_range(0, 3) : 0;
                delayTicks(REQ_DATA, d, NOISE_TX);
                tx_done = 1'b1;
                waitReq(REQ_RHAND, 8, lat, lows);
                checkOutput("recv_hand_lat", lat, TURN_CYC + 1);
                checkOutput("turn_gap_out", lows, TURN_CYC);
                checkOutput("recv_hand_drive", 32'(drive_bus), 0);
                d = rnd_delay ? $urandom_range(0, 3) : 0;
                delayTicks(REQ_RHAND, d, NOISE_WAITH);
                case (outc[a])
                    0: rx_ack = 1'b1;
                    1: rx_nak = 1'b1;
                    2: rx_hs_fail = 1'b1;
                    default: begin rx_ack = 1'b1; rx_nak = 1'b1; end
                endcase
            end else begin
                waitReq(REQ_RDATA, 8, lat, lows);
                checkOutput("recv_data_lat", lat, TURN_CYC + 1);
                checkOutput("turn_gap_in", lows, TURN_CYC);
                d = rnd_delay ? $urandom_range(0, 3) : 0;
                delayTicks(REQ_RDATA, d, NOISE_IND);
                case (outc[a])
                    0: rx_data_ok = 1'b1;
                    1: rx_data_fail = 1'b1;
                    default: begin rx_data_ok = 1'b1; rx_data_fail = 1'b1; end
                endcase
                waitReq(REQ_HS, 8, lat, lows);
                checkOutput("send_hs_lat", lat, TURN_CYC + 1);
                checkOutput("turn_gap_hs", lows, TURN_CYC);
                checkOutput("send_hs_drive", 32'(drive_bus), 1);
                checkOutput("hs_is_nak", 32'(hs_is_nak), (outc[a] != 0) ? 1 : 0);
                d = rnd_delay ? $urandom_range(0, 3) : 0;
                delayTicks(REQ_HS, d, NOISE_TX);
                tx_done = 1'b1;
            end
            if (outc[a] == 0) begin
                waitReq(REQ_DONE, 4, lat, lows);
                checkOutput("done_lat", lat, 1);
                break;
            end else if (a == MAX_RETRY) begin
                waitReq(REQ_DONE, 4, lat, lows);
                checkOutput("fail_done_lat", lat, 2);
            end else begin
                waitReq(REQ_TOKEN, 4, lat, lows);
                checkOutput("retry_token_lat", lat, 2);
            end
        end
        checkOutput("token_count", tokens, exp_att);
        checkOutput("txn_ok", 32'(txn_ok), 32'(exp_ok));
        checkOutput("retry_cnt", 32'(retry_cnt), exp_att - 1);
        tick();
        checkOutput("txn_done_single", 32'(txn_done), 0);
        checkOutput("retry_cnt_hold", 32'(retry_cnt), exp_att - 1);
        checkOutput("idle_after_txn", 32'(busy), 0);
        if (busy) doReset();
    endtask

    initial begin
        int lat, lows, r;
        logic is_in;
        clearPulses();
        txn_is_in = 1'b0;
        rst = 1'b1;
        #1;
        checkOutput("reset_outputs", 32'({send_token, send_data, send_hs, hs_is_nak, recv_data,
                    recv_hand, drive_bus, busy, txn_done, txn_ok, retry_cnt}), 0);
        repeat (2) @(posedge clk);
        #3;
        rst = 1'b0;
        tick();
        $display("[TB] reset released");

        // abort while idle must do nothing
        abort = 1'b1;
        tick();
        clearPulses();
        checkOutput("idle_abort_busy", 32'(busy), 0);
        checkOutput("idle_abort_done", 32'(txn_done), 0);

        // OUT success first time
        outc = '{0, 0, 0};
        applyStimulus(1'b0, 1'b0);
        // OUT: NAK, NAK, ACK
        outc = '{1, 1, 0};
        applyStimulus(1'b0, 1'b0);
        // IN: bad CRC then good
        outc = '{1, 0, 0};
        applyStimulus(1'b1, 1'b0);
        // OUT: handshake timeout every time -> exhausted
        outc = '{2, 2, 2};
        applyStimulus(1'b0, 1'b0);
        // ACK and NAK together counts as NAK, then success
        outc = '{3, 0, 0};
        applyStimulus(1'b0, 1'b1);
        // IN with good+bad together on every attempt -> exhausted
        outc = '{2, 2, 2};
        applyStimulus(1'b1, 1'b1);

        // abort while waiting for the handshake
        txn_start = 1'b1;
        txn_is_in = 1'b0;
        waitReq(REQ_TOKEN, 4, lat, lows);
        tx_done = 1'b1;
        waitReq(REQ_DATA, 6, lat, lows);
        tx_done = 1'b1;
        waitReq(REQ_RHAND, 8, lat, lows);
        abort = 1'b1;
        waitReq(REQ_DONE, 4, lat, lows);
        checkOutput("abort_lat", lat, 1);
        checkOutput("abort_txn_ok", 32'(txn_ok), 0);
        checkOutput("abort_no_requests", 32'({send_token, send_data, send_hs, recv_data, recv_hand}), 0);
        tick();
        checkOutput("abort_idle", 32'(busy), 0);

        // reset in the middle of IN_DATA clears outputs immediately
        txn_start = 1'b1;
        txn_is_in = 1'b1;
        waitReq(REQ_TOKEN, 4, lat, lows);
        tx_done = 1'b1;
        waitReq(REQ_RDATA, 8, lat, lows);
        checkOutput("pre_reset_busy", 32'(busy), 1);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("async_reset_outputs", 32'({send_token, send_data, send_hs, hs_is_nak, recv_data,
                    recv_hand, drive_bus, busy, txn_done, txn_ok, retry_cnt}), 0);
        repeat (2) @(posedge clk);
        #3;
        rst = 1'b0;
        tick();

        // randomized transactions with random delays, noise and ignored starts
        noise_en = 1'b1;
        for (int t = 0; t < 30; t++) begin
            is_in = 1'($urandom);
            for (int a = 0; a <= MAX_RETRY; a++) begin
                r = $urandom_range(0, 5);
                if (r < 3) outc[a] = 0;
                else outc[a] = is_in ? $urandom_range(1, 2) : $urandom_range(1, 3);
            end
            applyStimulus(is_in, 1'b1);
            repeat ($urandom_range(0, 2)) tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
